// File: rtl/uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | uart_tx_arbiter: round-robin sharing of one UART byte transmitter among    |
// | NUM_REQ producers. Optional UART_ARB_PACKET_EN adds packet grant locking.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       btn,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       data_in,
`ifdef UART_ARB_PACKET_EN
  input  logic [NUM_REQ-1:0]         last,
`endif
  output logic [NUM_REQ-1:0]         ack,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic                       tx_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     grant_id_q, grant_id_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
`ifdef UART_ARB_PACKET_EN
  logic               last_q, last_d;
`endif

  logic               sel_found;
  logic [IDW-1:0]     sel_idx;
  logic [7:0]         sel_byte;
  logic [IDW:0]       sum;
  logic [IDW-1:0]     next_ptr;
  logic [IDW-1:0]     done_ptr;

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NUM_REQ)) begin
        sum = sum - (IDW+1)'(NUM_REQ);
      end
      if (req[sum[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    sel_byte = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == IDW'(i)) begin
        sel_byte = data_in[8*i +: 8];
      end
    end
  end

  assign next_ptr = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

`ifdef UART_ARB_PACKET_EN
  // A packet lock is simply rr_ptr parked on the owner: the search then picks
  // it first, and falls through to round-robin as soon as its req drops.
  assign done_ptr = last_q ? next_ptr : grant_id_q;
`else
  assign done_ptr = next_ptr;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    ack_d         = '0;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;
`ifdef UART_ARB_PACKET_EN
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (sel_found && !tx_busy) begin
          tx_data_d        = sel_byte;
          tx_start_d       = 1'b1;
          ack_d[sel_idx]   = 1'b1;
          grant_id_d       = sel_idx;
          busy_d           = 1'b1;
          cnt_d            = '0;
          state_d          = WAIT_BUSY;
`ifdef UART_ARB_PACKET_EN
          last_d           = last[sel_idx];
`endif
        end
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Abandoned launch never holds a packet lock.
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          rr_ptr_d      = next_ptr;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          busy_d   = 1'b0;
          rr_ptr_d = done_ptr;
          state_d  = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      tx_data_q     <= 8'h00;
      tx_start_q    <= 1'b0;
      ack_q         <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
`ifdef UART_ARB_PACKET_EN
      last_q        <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
`ifdef UART_ARB_PACKET_EN
      last_q        <= last_d;
`endif
    end
  end

  assign ack         = ack_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_arbiter;

  logic        clk;
  logic        btn;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  last;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(15)) dut (
    .clk         (clk),
    .btn         (btn),
    .req         (req),
    .data_in     (data_in),
`ifdef UART_ARB_PACKET_EN
    .last        (last),
`endif
    .ack         (ack),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (tx_start !== 1'b1 && n < 20);
    check(tag, {31'd0, tx_start}, 32'd1);
  endtask

  // Called in the cycle tx_start is visible; completes a short frame.
  task automatic finish_frame(input string tag);
    tx_busy = 1'b1;
    tick();
    tick();
    tx_busy = 1'b0;
    tick();
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_reset();
    btn = 1'b0;
    tick();
    tick();
    btn = 1'b1;
  endtask

  initial begin
    btn     = 1'b0;
    req     = 4'b0000;
    data_in = 32'h0;
    last    = 4'b1111;
    tx_busy = 1'b0;
    tick();
    tick();
    check("rst_ack", {28'd0, ack}, 32'h0);
    check("rst_start", {31'd0, tx_start}, 32'h0);
    check("rst_data", {24'd0, tx_data}, 32'h0);
    check("rst_gid", {30'd0, grant_id}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    check("rst_err", {31'd0, timeout_err}, 32'h0);
    btn = 1'b1;
    tick();

    // Single requester, transmitter busy two cycles after start for 10 cycles
    req     = 4'b0010;
    data_in = 32'h0000_4100;
    tick();
    check("t1_ack", {28'd0, ack}, 32'h2);
    check("t1_start", {31'd0, tx_start}, 32'h1);
    check("t1_data", {24'd0, tx_data}, 32'h41);
    check("t1_gid", {30'd0, grant_id}, 32'h1);
    check("t1_busy", {31'd0, busy}, 32'h1);
    req = 4'b0000;
    tick();
    check("t1_ack_pulse", {28'd0, ack}, 32'h0);
    check("t1_start_pulse", {31'd0, tx_start}, 32'h0);
    tick();
    tx_busy = 1'b1;
    repeat (10) tick();
    check("t1_busy_hold", {31'd0, busy}, 32'h1);
    check("t1_data_hold", {24'd0, tx_data}, 32'h41);
    tx_busy = 1'b0;
    tick();
    check("t1_busy_end", {31'd0, busy}, 32'h0);
    check("t1_gid_end", {30'd0, grant_id}, 32'h1);

    // Fairness from rr_ptr=0 with all four requesting
    do_reset();
    req     = 4'b1111;
    data_in = 32'hA3A2_A1A0;
    for (int i = 0; i < 5; i++) begin
      wait_start("t2_start");
      check("t2_gid", {30'd0, grant_id}, 32'(i % 4));
      check("t2_data", {24'd0, tx_data}, 32'hA0 + 32'(i % 4));
      check("t2_ack", {28'd0, ack}, 32'(1 << (i % 4)));
      finish_frame("t2_done");
      check("t2_gap", {31'd0, tx_start}, 32'h0);
    end
    // rr_ptr now 1

    // Timeout: only requester 2, transmitter never answers
    req     = 4'b0100;
    data_in = 32'hC3C2_0000;
    tick();
    check("t3_gid", {30'd0, grant_id}, 32'h2);
    check("t3_start", {31'd0, tx_start}, 32'h1);
    req = 4'b0000;
    repeat (14) tick();
    check("t3_err_early", {31'd0, timeout_err}, 32'h0);
    check("t3_busy_early", {31'd0, busy}, 32'h1);
    tick();
    check("t3_err_set", {31'd0, timeout_err}, 32'h1);
    check("t3_busy_clr", {31'd0, busy}, 32'h0);
    req = 4'b1100;
    tick();
    check("t3_next_gid", {30'd0, grant_id}, 32'h3);
    check("t3_next_data", {24'd0, tx_data}, 32'hC3);
    req = 4'b0000;
    finish_frame("t3_done");
    check("t3_err_sticky", {31'd0, timeout_err}, 32'h1);

    // Transmitter busy elsewhere blocks the grant
    tx_busy = 1'b1;
    req     = 4'b0001;
    data_in = 32'h0000_0055;
    repeat (3) tick();
    check("t4_no_ack", {28'd0, ack}, 32'h0);
    check("t4_no_start", {31'd0, tx_start}, 32'h0);
    tx_busy = 1'b0;
    tick();
    check("t4_ack", {28'd0, ack}, 32'h1);
    check("t4_start", {31'd0, tx_start}, 32'h1);
    check("t4_data", {24'd0, tx_data}, 32'h55);
    req = 4'b0000;
    finish_frame("t4_done");

    // Reset while in WAIT_DONE
    req     = 4'b0100;
    data_in = 32'h8877_6655;
    tick();
    check("t5_gid", {30'd0, grant_id}, 32'h2);
    req     = 4'b0000;
    tx_busy = 1'b1;
    tick();
    tick();
    btn = 1'b0;
    #1;
    check("t5_rst_data", {24'd0, tx_data}, 32'h0);
    check("t5_rst_gid", {30'd0, grant_id}, 32'h0);
    check("t5_rst_busy", {31'd0, busy}, 32'h0);
    check("t5_rst_err", {31'd0, timeout_err}, 32'h0);
    check("t5_rst_start", {31'd0, tx_start}, 32'h0);
    tick();
    btn     = 1'b1;
    tx_busy = 1'b0;
    req     = 4'b1001;
    tick();
    check("t5_ptr0_gid", {30'd0, grant_id}, 32'h0);
    check("t5_ptr0_data", {24'd0, tx_data}, 32'h55);
    req = 4'b0000;
    finish_frame("t5_done");
    req = 4'b1000;
    tick();
    check("t5_gid3", {30'd0, grant_id}, 32'h3);
    check("t5_ack3", {28'd0, ack}, 32'h8);
    req = 4'b0000;
    finish_frame("t5_done3");

`ifdef UART_ARB_PACKET_EN
    // Packet lock: requester 0 sends three bytes, last only on the third
    do_reset();
    req     = 4'b0011;
    data_in = 32'h0000_2010;
    last    = 4'b1110;
    wait_start("t6_s0");
    check("t6_g0", {30'd0, grant_id}, 32'h0);
    check("t6_d0", {24'd0, tx_data}, 32'h10);
    data_in = 32'h0000_2011;
    finish_frame("t6_f0");
    wait_start("t6_s1");
    check("t6_g1", {30'd0, grant_id}, 32'h0);
    check("t6_d1", {24'd0, tx_data}, 32'h11);
    data_in = 32'h0000_2012;
    last    = 4'b1111;
    finish_frame("t6_f1");
    wait_start("t6_s2");
    check("t6_g2", {30'd0, grant_id}, 32'h0);
    check("t6_d2", {24'd0, tx_data}, 32'h12);
    data_in = 32'h0000_2013;
    finish_frame("t6_f2");
    wait_start("t6_s3");
    check("t6_g3", {30'd0, grant_id}, 32'h1);
    check("t6_d3", {24'd0, tx_data}, 32'h20);
    req = 4'b0000;
    finish_frame("t6_f3");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
